i2c_init_sequencer: RTL
=======================

// Module: i2c_init_sequencer
// PURPOSE
//  Upstream feeder for i2c_controller: walks a register-write table after power-up or on request.
//  Presents {dev_addr, reg_addr, data} to the controller, holds start until the controller goes busy,
//  then waits for ready before moving on. Inserts a programmable gap between writes.
//  Flags done or error to system logic. Typical use is sensor or codec initialisation.
// PARAMETERS
//  DEV_ADDR        8'h42   device address driven on i2c_dev_addr for every entry
//  NUM_ENTRIES     16      table depth; entries beyond the end marker are never read
//  GAP_CYCLES      50000   clk_in cycles between writes (1 ms @ 50 MHz); sim value 4
//  TIMEOUT_CYCLES  2000000 max clk_in cycles per handshake phase before error; sim value 64
// PORTS
//  clk_in        in   1    50 MHz system clock
//  reset_in      in   1    synchronous, active-low reset
//  go            in   1    start sequence (level sampled; acted on only in IDLE/DONE/ERROR)
//  i2c_ready     in   1    ready_out of i2c_controller (slow-clock domain, synchronised here)
//  i2c_start     out  1    start to controller
//  i2c_dev_addr  out  8    to controller dev_addr
//  i2c_reg_addr  out  8    to controller reg_addr
//  i2c_data      out  8    to controller data
//  busy          out  1    sequence in progress
//  done          out  1    table completed (sticky until next go)
//  error         out  1    handshake timeout (sticky until next go)
//  entry_idx     out  IW   current or failing table index, IW = $clog2(NUM_ENTRIES+1)
// BEHAVIOUR
//  - Reset (reset_in==0 at a clk_in edge): state IDLE. All outputs are 0, except i2c_dev_addr=DEV_ADDR.
//    Applies mid-write too: i2c_start drops at that edge. No bus cleanup is attempted.
//  - i2c_ready passes through a 2-flop synchroniser (rdy_s) and takes 2 cycles to appear; all checks below use rdy_s.
//  - Table entry is 16 bits: {reg, data}. Entry 16'hFFFF is the end marker.
//  - IDLE/DONE/ERROR: go==1 -> FETCH; entry_idx=0, busy=1, done=0, error=0.
//  - FETCH: ROM output is registered, so each entry takes 1 cycle.
//      End marker, or entry_idx==NUM_ENTRIES -> DONE.
//      Otherwise latch i2c_reg_addr/i2c_data -> ISSUE.
//  - ISSUE: wait for rdy_s==1, then i2c_start=1, clear timer -> WAIT_ACK.
//  - WAIT_ACK: hold i2c_start=1 until rdy_s==0, because the controller clock is 500x slower and a
//    1-cycle pulse would be missed. Then i2c_start=0, clear timer -> WAIT_DONE.
//  - WAIT_DONE: rdy_s==1 -> GAP, clear timer.
//  - Timeout in ISSUE, WAIT_ACK or WAIT_DONE: timer reaching TIMEOUT_CYCLES-1 -> ERROR.
//    i2c_start=0, busy=0, error=1, entry_idx frozen.
//  - GAP: count GAP_CYCLES; at terminal count entry_idx+1 -> FETCH.
//  - DONE: busy=0, done=1, entry_idx = number of writes performed.
//  - go while busy is ignored. go held high in DONE or ERROR restarts the sequence each time it completes.
//  - i2c_reg_addr/i2c_data stay stable from ISSUE through WAIT_DONE, and are only changed in FETCH.
//  - Timer width: $clog2(max(GAP_CYCLES,TIMEOUT_CYCLES)+1). It saturates and never wraps.
//  - Adding entry_idx is safe from overflow: it is capped by the NUM_ENTRIES check in FETCH.
// STRUCTURE
//  - Shared package i2c_pkg: state enum localparams (IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_DONE, GAP,
//    DONE, ERROR) and END_MARKER=16'hFFFF. Entry field slices: REG=[15:8], DATA=[7:0].
//  - Sub-module i2c_init_rom: a registered case-table, NUM_ENTRIES x 16, addressed by entry_idx.
//    Returns END_MARKER for unused rows.
//  - The sequencer FSM, timer and synchroniser stay in this module.
// TESTING (GAP_CYCLES=4, TIMEOUT_CYCLES=64; behavioural controller model: ready falls 10 cycles
//          after start seen, rises 40 cycles later)
//  1. ROM {0x12_80, 0x11_01, FFFF}, pulse go.
//     -> two writes observed, (0x42,0x12,0x80) then (0x42,0x11,0x01); done=1, entry_idx=2, error=0.
//  2. Model ignores start (ready stays 1).
//     -> i2c_start held 64 cycles, then 0; error=1, entry_idx=0, busy=0.
//  3. Model stays busy (ready stuck 0 after ack) on entry 1.
//     -> error=1 after 64 cycles in WAIT_DONE, entry_idx=1.
//  4. reset_in=0 during WAIT_ACK of entry 0.
//     -> next edge: i2c_start=0, busy=0, idle outputs; a later go restarts at entry 0.
//  5. go pulsed during WAIT_DONE.
//     -> ignored; sequence completes once, done=1.
//  6. Full table with no end marker (16 entries).
//     -> 16 writes, done=1, entry_idx=16; gap between ready rise and next start >= 4 cycles.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: FSM states, table-entry layout, helpers.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        GAP,
        DONE,
        ERROR
    } seq_state_t;

    // A table row of all ones terminates the write list.
    localparam logic [15:0] END_MARKER = 16'hFFFF;

    // Entry layout: {reg_addr, data}.
    localparam int REG_MSB  = 15;
    localparam int REG_LSB  = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    function automatic logic [7:0] entry_reg(input logic [15:0] entry);
        return entry[REG_MSB:REG_LSB];
    endfunction

    function automatic logic [7:0] entry_data(input logic [15:0] entry);
        return entry[DATA_MSB:DATA_LSB];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/i2c_init_rom.sv
// Register-write table: NUM_ENTRIES x 16 lookup with a registered output.
// Rows outside the table read back as the end marker.
module i2c_init_rom
    import i2c_pkg::*;
#(
    parameter int                          NUM_ENTRIES = 16,
    parameter int                          AW          = 5,
    parameter logic [NUM_ENTRIES*16-1:0]   TABLE       = '1
) (
    input  logic          clk_in,
    input  logic [AW-1:0] addr,
    output logic [15:0]   entry
);

    logic [15:0] entry_d;

    // Case-table decode of the addressed row; unmatched addresses give the end marker.
    always_comb begin
        entry_d = END_MARKER;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (addr == AW'(i)) begin
                entry_d = TABLE[i*16 +: 16];
            end
        end
    end

    // Registered ROM output, one cycle after the address.
    always_ff @(posedge clk_in) begin
        entry <= entry_d;
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a register-write table and feeds each entry to an i2c_controller.
// Holds start until the slow controller drops ready, waits for ready to return,
// inserts a gap between writes, and reports done or a handshake timeout.
module i2c_init_sequencer
    import i2c_pkg::*;
#(
    parameter logic [7:0]                DEV_ADDR       = 8'h42,
    parameter int                        NUM_ENTRIES    = 16,
    parameter int                        GAP_CYCLES     = 50000,
    parameter int                        TIMEOUT_CYCLES = 2000000,
    parameter logic [NUM_ENTRIES*16-1:0] INIT_TABLE     =
        {{(NUM_ENTRIES-2){END_MARKER}}, 16'h1101, 16'h1280},
    localparam int                       IW             = $clog2(NUM_ENTRIES + 1)
) (
    input  logic          clk_in,
    input  logic          reset_in,
    input  logic          go,
    input  logic          i2c_ready,
    output logic          i2c_start,
    output logic [7:0]    i2c_dev_addr,
    output logic [7:0]    i2c_reg_addr,
    output logic [7:0]    i2c_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [IW-1:0] entry_idx
);

    localparam int            TW           = $clog2(max_int(GAP_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [TW-1:0] TIMER_MAX    = '1;
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_END      = IW'(NUM_ENTRIES);

    seq_state_t    state_q;
    seq_state_t    state_d;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] idx_d;
    logic [TW-1:0] timer_q;
    logic          timer_clr;
    logic          timeout;
    logic          load_entry;
    logic [7:0]    reg_q;
    logic [7:0]    data_q;
    logic          rdy_meta_p0;
    logic          rdy_s;
    logic [15:0]   rom_entry;

    // The ROM is addressed with the next index so the row is ready during FETCH.
    i2c_init_rom #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .AW          (IW),
        .TABLE       (INIT_TABLE)
    ) u_rom (
        .clk_in (clk_in),
        .addr   (idx_d),
        .entry  (rom_entry)
    );

    // Two-flop synchroniser for ready coming from the controller's slow clock domain.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            rdy_meta_p0 <= 1'b0;
            rdy_s       <= 1'b0;
        end else begin
            rdy_meta_p0 <= i2c_ready;
            rdy_s       <= rdy_meta_p0;
        end
    end

    assign timeout = (timer_q >= TIMEOUT_LAST);

    // Next-state logic: table walk, handshake with the controller, gap and timeout.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_clr  = 1'b0;
        load_entry = 1'b0;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (go) begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
            end
            FETCH: begin
                if (rom_entry == END_MARKER || idx_q == IDX_END) begin
                    state_d = DONE;
                end else begin
                    state_d    = ISSUE;
                    load_entry = 1'b1;
                    timer_clr  = 1'b1;
                end
            end
            ISSUE: begin
                if (rdy_s) begin
                    state_d   = WAIT_ACK;
                    timer_clr = 1'b1;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            WAIT_ACK: begin
                // Start stays high until the controller visibly goes busy.
                if (!rdy_s) begin
                    state_d   = WAIT_DONE;
                    timer_clr = 1'b1;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            WAIT_DONE: begin
                if (rdy_s) begin
                    state_d   = GAP;
                    timer_clr = 1'b1;
                end else if (timeout) begin
                    state_d = ERROR;
                end
            end
            GAP: begin
                if (timer_q == GAP_LAST) begin
                    state_d = FETCH;
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and table index registers.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Shared gap/timeout timer; saturates instead of wrapping.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            timer_q <= '0;
        end else if (timer_clr) begin
            timer_q <= '0;
        end else if (timer_q != TIMER_MAX) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // Entry fields are captured only in FETCH and held through the whole handshake.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            reg_q  <= '0;
            data_q <= '0;
        end else if (load_entry) begin
            reg_q  <= entry_reg(rom_entry);
            data_q <= entry_data(rom_entry);
        end
    end

    assign i2c_start    = (state_q == WAIT_ACK);
    assign i2c_dev_addr = DEV_ADDR;
    assign i2c_reg_addr = reg_q;
    assign i2c_data     = data_q;
    assign busy         = state_q inside {FETCH, ISSUE, WAIT_ACK, WAIT_DONE, GAP};
    assign done         = (state_q == DONE);
    assign error        = (state_q == ERROR);
    assign entry_idx    = idx_q;

endmodule
